perf_event_select: RTL and testbench

Programmable event-selection stage directly upstream of the performance counter bank. Samples raw per-cycle event counts from the caches, MMU, issue, frontend and commit stages, and routes one selected event to each counter slot under software control. Applies debug-mode gating and a per-slot inhibit mask. Emits registered per-slot increment values that the counter bank adds to its counters.

---
 rtl/perf_event_select.sv | 86 ++++++++
 tb/tb_perf_event_select.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_select.sv
// Event-selection stage feeding the performance counter bank: samples raw event
// counts, routes one event per slot, applies debug gating and inhibit masking.
module perf_event_select #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned NumEvents   = 16,
  parameter int unsigned IncWidth    = 2,
  parameter int unsigned Xlen        = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                debug_mode_i,
  input  logic [3:0]                          cfg_addr_i,
  input  logic                                cfg_we_i,
  input  logic [Xlen-1:0]                     cfg_data_i,
  output logic [Xlen-1:0]                     cfg_data_o,
  input  logic [NumEvents-1:0][IncWidth-1:0]  event_cnt_i,
  output logic [NumCounters-1:0][IncWidth-1:0] inc_o
);

  localparam int unsigned SelW        = $clog2(NumEvents);
  localparam logic [3:0]  InhibitAddr = 4'd15;

  logic [NumCounters-1:0][SelW-1:0]     sel_q;
  logic [NumCounters-1:0]               inhibit_q, inhibit_d;
  logic [NumCounters-1:0]               wr_blank_q, sel_wr;
  logic [NumEvents-1:0][IncWidth-1:0]   ev_q, ev_d;
  logic [NumCounters-1:0][IncWidth-1:0] inc_q, inc_d;
  logic                                 unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data_i;
  assign inc_o           = inc_q;

  // Config write decode; the inhibit mask being written takes effect on this edge.
  always_comb begin
    sel_wr    = '0;
    inhibit_d = inhibit_q;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (cfg_we_i && (cfg_addr_i == 4'(i))) sel_wr[i] = 1'b1;
    end
    if (cfg_we_i && (cfg_addr_i == InhibitAddr)) inhibit_d = cfg_data_i[NumCounters-1:0];
  end

  // Read-before-write register readback.
  always_comb begin
    cfg_data_o = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (cfg_addr_i == 4'(i)) cfg_data_o = Xlen'(sel_q[i]);
    end
    if (cfg_addr_i == InhibitAddr) cfg_data_o = Xlen'(inhibit_q);
  end

  // Stage 1: debug-gated sample; source 0 is "no event".
  always_comb begin
    ev_d    = debug_mode_i ? '0 : event_cnt_i;
    ev_d[0] = '0;
  end

  // Stage 2: per-slot routing with inhibit and post-reprogram blanking.
  always_comb begin
    inc_d = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (!inhibit_d[i] && !wr_blank_q[i] && (32'(sel_q[i]) < NumEvents)) begin
        inc_d[i] = ev_q[sel_q[i]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q      <= '0;
      inhibit_q  <= '0;
      wr_blank_q <= '0;
      ev_q       <= '0;
      inc_q      <= '0;
    end else begin
      ev_q       <= ev_d;
      inc_q      <= inc_d;
      inhibit_q  <= inhibit_d;
      wr_blank_q <= sel_wr;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        if (sel_wr[i]) sel_q[i] <= cfg_data_i[SelW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_perf_event_select.sv
// Scoreboard bench for perf_event_select: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_perf_event_select;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              debug_mode_i;
  logic [3:0]        cfg_addr_i;
  logic              cfg_we_i;
  logic [63:0]       cfg_data_i;
  logic [63:0]       cfg_data_o;
  logic [15:0][1:0]  event_cnt_i;
  logic [5:0][1:0]   inc_o;

  perf_event_select dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .debug_mode_i (debug_mode_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_data_o   (cfg_data_o),
    .event_cnt_i  (event_cnt_i),
    .inc_o        (inc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    bit          rd;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle, flag any that slipped past.
  always @(negedge clk_i) begin
    int i;
    logic [63:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed at cyc=%0d", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        act = sb[i].rd ? cfg_data_o : 64'(inc_o[sb[i].idx]);
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d idx=%0d actual=%0h required=%0h",
                   sb[i].name, cyc, sb[i].idx, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    cfg_addr_i = a;
    cfg_data_i = d;
    cfg_we_i   = 1'b1;
  endtask

  task automatic exp_inc(input int c, input int slot, input int v, input string n);
    exp_t e;
    e = '{cyc: c, rd: 1'b0, idx: slot, val: 64'(v), name: n};
    sb.push_back(e);
  endtask

  task automatic exp_rd(input int c, input logic [63:0] v, input string n);
    exp_t e;
    e = '{cyc: c, rd: 1'b1, idx: 0, val: v, name: n};
    sb.push_back(e);
  endtask

  initial begin
    int w, a, s, b, p, q, r;
    rst_ni = 1'b0; debug_mode_i = 1'b0; cfg_addr_i = '0; cfg_we_i = 1'b0;
    cfg_data_i = '0; event_cnt_i = '0;
    step(); step();
    rst_ni = 1'b1;
    event_cnt_i[3] = 2'd1;
    event_cnt_i[0] = 2'd3;

    // All selects at 0: nothing counts, all registers read 0.
    for (int k = 0; k < 7; k++) begin
      step();
      cfg_addr_i = (k < 6) ? 4'(k) : 4'd15;
      exp_rd(cyc, 64'd0, "rd_reset");
      for (int sl = 0; sl < 6; sl++) exp_inc(cyc, sl, 0, "inc_sel0");
    end

    // Select write with blanking and read-before-write.
    step(); event_cnt_i[3] = 2'd2;
    step(); step();
    w = cyc;
    wr(4'd2, 64'd3);
    exp_rd(w, 64'd0, "rd_before_wr");
    exp_inc(w + 1, 2, 0, "inc_sel_w1");
    exp_inc(w + 2, 2, 0, "inc_sel_blank");
    exp_inc(w + 3, 2, 2, "inc_sel_new");
    exp_inc(w + 4, 2, 2, "inc_sel_new2");
    step(); cfg_addr_i = 4'd2;
    exp_rd(w + 1, 64'd3, "rd_after_wr");
    step(); step(); step();

    // Shared event across two slots, inhibit mask applied then cleared.
    step(); a = cyc;
    event_cnt_i[5] = 2'd3;
    wr(4'd0, 64'd5);
    step(); wr(4'd1, 64'd5);
    step(); wr(4'd15, 64'd2);
    exp_inc(a + 5, 0, 3, "inc_shared0");
    exp_inc(a + 6, 0, 3, "inc_shared0b");
    exp_inc(a + 5, 1, 0, "inc_inhibit1");
    exp_inc(a + 6, 1, 0, "inc_inhibit1b");
    exp_inc(a + 6, 2, 2, "inc_slot2_hold");
    step(); step();
    step(); cfg_addr_i = 4'd15;
    exp_rd(a + 5, 64'd2, "rd_inhibit");
    step(); step();
    w = cyc;
    wr(4'd15, 64'd0);
    exp_inc(w, 1, 0, "inc_uninhibit_w");
    exp_inc(w + 1, 1, 3, "inc_uninhibit_w1");
    exp_inc(w + 2, 1, 3, "inc_uninhibit_w2");

    // Debug gating on the sample cycle.
    step(); step();
    s = cyc;
    wr(4'd4, 64'd7);
    b = s + 3;
    exp_inc(b + 1, 4, 0, "inc_dbg_pre");
    for (int c = 2; c <= 4; c++) exp_inc(b + c, 4, 1, "inc_dbg_before");
    for (int c = 5; c <= 7; c++) exp_inc(b + c, 4, 0, "inc_dbg_gated");
    for (int c = 8; c <= 11; c++) exp_inc(b + c, 4, 1, "inc_dbg_after");
    exp_inc(b + 12, 4, 0, "inc_dbg_end");
    exp_inc(b + 6, 0, 0, "inc_dbg_other");
    exp_inc(b + 9, 0, 3, "inc_dbg_other_after");
    while (cyc < b + 12) begin
      step();
      event_cnt_i[7] = (cyc >= b && cyc <= b + 9) ? 2'd1 : 2'd0;
      debug_mode_i   = (cyc >= b + 3 && cyc <= b + 5);
    end

    // Truncated select, unmapped address, select 0.
    step(); p = cyc;
    wr(4'd0, 64'hFFFF);
    event_cnt_i[15] = 2'd1;
    exp_inc(p + 3, 0, 1, "inc_sel15");
    exp_inc(p + 4, 0, 1, "inc_sel15b");
    step(); cfg_addr_i = 4'd0; exp_rd(p + 1, 64'd15, "rd_sel_trunc");
    step(); wr(4'd9, 64'd7);
    step(); cfg_addr_i = 4'd9;  exp_rd(p + 3, 64'd0, "rd_unmapped9");
    step(); cfg_addr_i = 4'd1;  exp_rd(p + 4, 64'd5, "rd_sel1_kept");
    step(); cfg_addr_i = 4'd4;  exp_rd(p + 5, 64'd7, "rd_sel4_kept");
    step(); cfg_addr_i = 4'd6;  exp_rd(p + 6, 64'd0, "rd_unmapped6");
    step(); cfg_addr_i = 4'd15; exp_rd(p + 7, 64'd0, "rd_inhibit_kept");
    step(); q = cyc;
    wr(4'd0, 64'd0);
    exp_inc(q + 3, 0, 0, "inc_no_event");
    exp_inc(q + 4, 0, 0, "inc_no_event2");
    step(); cfg_addr_i = 4'd0; exp_rd(q + 1, 64'd0, "rd_sel0");
    step(); step(); step();

    // Asynchronous reset mid-stream.
    step(); r = cyc;
    exp_inc(r, 2, 2, "inc_pre_rst");
    step();
    rst_ni = 1'b0;
    exp_inc(r + 1, 2, 0, "inc_async_rst");
    exp_inc(r + 1, 1, 0, "inc_async_rst1");
    step(); step();
    rst_ni = 1'b1;
    cfg_addr_i = 4'd2; exp_rd(r + 3, 64'd0, "rd_rst_sel2");
    step(); cfg_addr_i = 4'd4; exp_rd(r + 4, 64'd0, "rd_rst_sel4");
    step(); cfg_addr_i = 4'd1; exp_rd(r + 5, 64'd0, "rd_rst_sel1");
    exp_inc(r + 5, 2, 0, "inc_post_rst");

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
